// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. The line is synchronized, a falling edge in
// IDLE starts a frame, the start bit is re-checked at mid-bit, then eight
// data bits (LSB first) and the stop bit are sampled at bit centres.
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic       RS232_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = $clog2(BIT_CNT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic             sync1, sync2, sync_d;
    logic [1:0]       sync_vld;
    logic             armed;

    logic             start_edge;
    logic             cnt_clr;
    logic             bit_take;
    logic             done_set;
    logic             ferr_set;

    // Synchronizer, edge-detect delay flop, and the arming flag.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse the chain.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync_d   <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sync1    <= RS232_rx;
            sync2    <= sync1;
            sync_d   <= sync2;
            sync_vld <= {sync_vld[0], 1'b1};
            // The reset value of 1 in the chain is not a real observation of
            // the line; only arm once a genuine high has reached sync2, so a
            // line held low across reset release never looks like a start.
            if (sync_vld[1] && sync2)
                armed <= 1'b1;
        end
    end

    assign start_edge = armed && !sync2 && sync_d && (state == IDLE);
    assign rx_busy    = (state != IDLE);

    // FSM state register.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state decode and per-cycle datapath strobes.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        bit_take   = 1'b0;
        done_set   = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                    cnt_clr    = 1'b1;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    // Line back high at mid start bit: treat as a glitch.
                    state_next = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    bit_take = 1'b1;
                    if (bit_idx == 3'd7)
                        state_next = STOP;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a directly following start bit is
                // still caught by the edge detector.
                if (baud_cnt == BIT_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                    done_set   = sync2;
                    ferr_set   = !sync2;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Baud counter, bit index, shift register and registered outputs.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (cnt_clr || state == IDLE)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state == IDLE)
                bit_idx <= 3'd0;
            else if (bit_take)
                bit_idx <= bit_idx + 3'd1;   // 7 -> 0 on the last data bit

            if (bit_take)
                shift_reg[bit_idx] <= sync2;

            if (done_set)
                rx_data <= shift_reg;

            rx_done   <= done_set;
            frame_err <= ferr_set;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx. The stimulus side pushes the
// expected pulse (kind, data, cycle) into a queue; a monitor pops and checks
// every rx_done / frame_err pulse it sees.
`timescale 1ns/1ps
module tb_uart_rx;

    // Scaled so a frame is a few hundred cycles: 16 clocks per bit.
    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 62500;
    localparam int BIT       = 16;
    localparam int HALF      = 8;
    // Falling edge to first cycle rx_done is seen: 2 sync + 1 FSM entry,
    // half a bit, 8 data bits and the stop bit to its sample point.
    localparam int LAT       = 9 * BIT + HALF + 3;

    logic       sclk;
    logic       reset;
    logic       RS232_rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    typedef struct {
        logic        is_err;
        logic [7:0]  data;
        int unsigned at_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc       = 0;
    int          n_vec     = 0;
    int          n_miss    = 0;
    logic [7:0]  last_good = 8'h00;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .sclk      (sclk),
        .reset     (reset),
        .RS232_rx  (RS232_rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial sclk = 1'b0;
    always #10 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge sclk) begin
        if (rx_done || frame_err) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b, want none (cycle %0d)",
                         rx_done, frame_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
                check("rx_done",   {31'd0, rx_done},   {31'd0, !e.is_err});
                check("rx_data",   {24'd0, rx_data},   {24'd0, e.data});
                check("pulse_cyc", cyc, e.at_cyc);
            end
        end
    end

    task automatic idle_bits(input int n);
        RS232_rx = 1'b1;
        repeat (n * BIT) @(negedge sclk);
    endtask

    // Called at a negedge; returns at the negedge ending the stop bit, so
    // consecutive calls are back-to-back frames.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_pulse);
        if (expect_pulse) begin
            exp_t e;
            e.is_err = !stop_bit;
            e.data   = stop_bit ? b : last_good;
            e.at_cyc = cyc + LAT;
            sb.push_back(e);
            if (stop_bit)
                last_good = b;
        end
        RS232_rx = 1'b0;
        repeat (BIT) @(negedge sclk);
        for (int i = 0; i < 8; i++) begin
            RS232_rx = b[i];
            repeat (BIT) @(negedge sclk);
        end
        RS232_rx = stop_bit;
        repeat (BIT) @(negedge sclk);
        RS232_rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"},   {24'd0, rx_data},   32'h00);
        check({tag, "_rx_done"},   {31'd0, rx_done},   32'h0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'h0);
        check({tag, "_rx_busy"},   {31'd0, rx_busy},   32'h0);
    endtask

    initial begin
        int unsigned c0;
        logic        seen_busy;

        reset    = 1'b0;
        RS232_rx = 1'b1;
        repeat (3) @(negedge sclk);
        check_reset_outputs("reset");
        reset = 1'b1;
        idle_bits(2);

        // Basic frame.
        send_frame(8'hC3, 1'b1, 1'b1);
        idle_bits(2);

        // 3-cycle low glitch: busy for exactly HALF cycles, no pulse.
        c0 = cyc;
        RS232_rx = 1'b0;
        repeat (3) @(negedge sclk);
        RS232_rx = 1'b1;
        while (cyc != c0 + 10) @(negedge sclk);
        check("glitch_busy_hi", {31'd0, rx_busy}, 32'h1);
        @(negedge sclk);
        check("glitch_busy_lo", {31'd0, rx_busy}, 32'h0);
        check("glitch_rx_data", {24'd0, rx_data}, {24'd0, last_good});
        idle_bits(2);

        // Stop bit low, then a good frame.
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(2);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_bits(2);

        // Back-to-back frames; exact latency on each implies 10-bit spacing.
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b1);
        idle_bits(2);

        // Same byte twice, as a transmitter loopback would produce.
        send_frame(8'hC3, 1'b1, 1'b1);
        idle_bits(1);
        send_frame(8'hC3, 1'b1, 1'b1);
        idle_bits(2);

        // Reset in the middle of data bit 4: frame aborted silently.
        fork
            send_frame(8'h7E, 1'b1, 1'b0);
        join_none
        repeat (5 * BIT + HALF) @(negedge sclk);
        reset = 1'b0;
        @(negedge sclk);
        check_reset_outputs("midreset");
        wait fork;
        last_good = 8'h00;
        idle_bits(1);
        reset = 1'b1;
        idle_bits(2);
        check_reset_outputs("postreset");
        send_frame(8'h81, 1'b1, 1'b1);
        idle_bits(2);

        // Reset released with the line low must not start a frame.
        reset    = 1'b0;
        RS232_rx = 1'b0;
        repeat (3) @(negedge sclk);
        reset     = 1'b1;
        seen_busy = 1'b0;
        repeat (3 * BIT) begin
            @(negedge sclk);
            if (rx_busy) seen_busy = 1'b1;
        end
        check("low_release_busy", {31'd0, seen_busy}, 32'h0);
        last_good = 8'h00;
        idle_bits(2);
        send_frame(8'h96, 1'b1, 1'b1);
        idle_bits(2);

        check("pending_expect", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning sclk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate in bit/s.
REQ-003 SHALL have port sclk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RS232_rx  input  1  serial line, idle high, asynchronous to sclk.
REQ-006 SHALL have port rx_data  output  8  last correctly framed received byte.
REQ-007 SHALL have port rx_done  output  1  one-cycle pulse: rx_data has just been updated.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
REQ-009 SHALL have port rx_busy  output  1  high while a frame is being received (any state other than IDLE).

Function
REQ-010 SHALL define BIT_CNT = CLK_FREQ/BAUD_RATE (integer truncation) and HALF_CNT = BIT_CNT/2; defaults give 5208 and 2604.
REQ-011 SHALL pass RS232_rx through a 2-flop synchronizer, reset value 1, plus one further delay flop for edge detection.
REQ-012 SHALL detect a start edge when the synchronized line is 0 and the delayed copy is 1, and only in IDLE.
REQ-013 SHALL use the FSM states IDLE, START, DATA, STOP; the reset state is IDLE.
REQ-014 IDLE -> START on a start edge; the baud counter is cleared to 0 on entry.
REQ-015 In START, at baud count HALF_CNT-1, SHALL sample the line: 0 -> DATA with the counter cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 In DATA, at each baud count BIT_CNT-1, SHALL sample one bit into shift-register position bit_idx (LSB first), clear the counter and increment bit_idx.
REQ-017 After the 8th data sample (bit_idx 7), SHALL go to STOP, with bit_idx reset to 0.
REQ-018 In STOP, at baud count BIT_CNT-1 (mid stop bit), SHALL sample the line: 1 -> load rx_data from the shift register and pulse rx_done; 0 -> pulse frame_err and leave rx_data unchanged; in both cases -> IDLE.
REQ-019 rx_done or frame_err SHALL be high for exactly the one cycle after the stop-bit sample edge; they are never high together.
REQ-020 The FSM SHALL return to IDLE at mid stop bit, so that a start bit immediately following a stop bit is captured (back-to-back frames).
REQ-021 After a frame_err, SHALL not re-arm until the synchronized line has been seen high (the edge-detect rule already enforces this).
REQ-022 The baud counter SHALL be wide enough for BIT_CNT-1 (13 bits at defaults) and SHALL never wrap within a state.
REQ-023 rx_data SHALL hold its value between frames; it changes only on a rx_done cycle.

Reset
REQ-024 On reset low, regardless of sclk: state=IDLE, counters=0, shift register=0, rx_data=8'h00, rx_done=0, frame_err=0, rx_busy=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block waits for a new falling edge.
REQ-026 Release of reset while RS232_rx is low SHALL NOT be treated as a start edge.

Verification
REQ-027 At 50 MHz with defaults, send 0xC3 at 9600 baud (bit time 104160 ns) -> rx_data=8'hC3, one rx_done pulse about 9.5 bit times plus 3 cycles after the falling edge, frame_err=0.
REQ-028 A 1 us low glitch on an idle line -> no rx_done, no frame_err; rx_busy falls back after HALF_CNT cycles; rx_data unchanged.
REQ-029 Send 0xA5 with the stop bit forced low -> one frame_err pulse, rx_done=0, rx_data keeps its previous value; then a valid 0x3C is received correctly.
REQ-030 Send 0x55 then 0xAA back-to-back (no idle gap) -> two rx_done pulses, 10 bit times apart, with rx_data 8'h55 then 8'hAA.
REQ-031 Assert reset in the middle of data bit 4 of a frame, then release -> no pulse, all outputs at reset values, and the next 0x81 frame is received correctly.
REQ-032 Loop back uart_tx RS232_tx to RS232_rx and send 0xC3 twice via tx_trig -> two rx_done pulses, with rx_data=8'hC3 each time.
